// File: rtl/const_encoder.sv
// Immediate encoder: turns a 16-bit constant into an LBI or LBI+SLBI
// sequence for a destination register, and reports immediate-field fit.
module const_encoder #(
  parameter logic [4:0] LBI_OP  = 5'b11000,
  parameter logic [4:0] SLBI_OP = 5'b10010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic [2:0]  ReqRd,
  input  logic [15:0] ReqValue,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [15:0] Instr,
  output logic        InstrLast,
  output logic [3:0]  Fit
);

  typedef enum logic [1:0] {
    IDLE,
    EMIT_LBI,
    EMIT_SLBI
  } state_t;

  state_t      state;
  logic [2:0]  rd;
  logic [7:0]  lo;
  logic [3:0]  fit_nx;

  always_comb begin
    fit_nx    = 4'b0000;
    fit_nx[0] = (&ReqValue[15:4]) | ~(|ReqValue[15:4]);
    fit_nx[1] = ~(|ReqValue[15:5]);
    fit_nx[2] = (&ReqValue[15:7]) | ~(|ReqValue[15:7]);
    fit_nx[3] = (&ReqValue[15:10]) | ~(|ReqValue[15:10]);
  end

  assign ReqReady = (state == IDLE);

  // The LBI word is built at accept time so Instr is purely registered;
  // only the low byte is kept for the optional SLBI.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      InstrValid <= 1'b0;
      Instr      <= 16'h0000;
      InstrLast  <= 1'b0;
      Fit        <= 4'b0000;
      rd         <= 3'd0;
      lo         <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (ReqValid) begin
            rd         <= ReqRd;
            lo         <= ReqValue[7:0];
            Fit        <= fit_nx;
            Instr      <= {LBI_OP, ReqRd,
                           fit_nx[2] ? ReqValue[7:0]
                                     : ReqValue[15:8]};
            InstrLast  <= fit_nx[2];
            InstrValid <= 1'b1;
            state      <= EMIT_LBI;
          end
        end
        EMIT_LBI: begin
          if (InstrReady) begin
            if (Fit[2]) begin
              state      <= IDLE;
              InstrValid <= 1'b0;
              InstrLast  <= 1'b0;
            end else begin
              state     <= EMIT_SLBI;
              Instr     <= {SLBI_OP, rd, lo};
              InstrLast <= 1'b1;
            end
          end
        end
        EMIT_SLBI: begin
          if (InstrReady) begin
            state      <= IDLE;
            InstrValid <= 1'b0;
            InstrLast  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
